lib_cntr_monitor: RTL

- Downstream checker for lib_sample.
- Samples the three counter outputs and the divided clock every CLK cycle.
- Verifies that each value advanced exactly as expected, and reports sticky per-channel errors plus a saturating error count.
- Used in self-test mode to qualify the counter/divider stage before its outputs are used elsewhere.

---
 rtl/lib_cntr_monitor_if.sv | 29 ++
 rtl/lib_cntr_monitor.sv | 112 +++++++++++
 2 files changed

// File: rtl/lib_cntr_monitor_if.sv
// Signal bundle between the session controller / counter stage (master) and lib_cntr_monitor (slave).
interface lib_cntr_monitor_if #(
   parameter int WIDTH     = 3,
   parameter int ERR_CNT_W = 8
);
   logic                 START;
   logic                 STOP;
   logic                 CLR_ERR;
   logic                 SELECT_3;
   logic [WIDTH-1:0]     CNTR_IN1;
   logic [WIDTH-1:0]     CNTR_IN2;
   logic [WIDTH-1:0]     CNTR_IN3;
   logic                 DIV_IN;
   logic                 BUSY;
   logic                 LOCKED;
   logic                 ERR;
   logic [3:0]           ERR_MASK;
   logic [ERR_CNT_W-1:0] ERR_CNT;

   modport master (
      output START, STOP, CLR_ERR, SELECT_3, CNTR_IN1, CNTR_IN2, CNTR_IN3, DIV_IN,
      input  BUSY, LOCKED, ERR, ERR_MASK, ERR_CNT
   );

   modport slave (
      input  START, STOP, CLR_ERR, SELECT_3, CNTR_IN1, CNTR_IN2, CNTR_IN3, DIV_IN,
      output BUSY, LOCKED, ERR, ERR_MASK, ERR_CNT
   );
endinterface

// File: rtl/lib_cntr_monitor.sv
// Checks that the three counters step by +1 and the divided clock toggles; sticky per-channel errors.
// Mismatch in cycle N shows on the outputs in cycle N+1; no backpressure, samples every cycle.
module lib_cntr_monitor #(
   parameter int WIDTH       = 3,
   parameter int ERR_CNT_W   = 8,
   parameter int SYNC_CYCLES = 2
) (
   input  logic              CLK,
   input  logic              RST,
   lib_cntr_monitor_if.slave mon
);
   typedef enum logic [1:0] {IDLE, SYNC, CHECK} state_t;

   localparam logic [3:0]           SYNC_LAST = 4'(SYNC_CYCLES - 1);
   localparam logic [WIDTH-1:0]     ONE       = WIDTH'(1);
   localparam logic [ERR_CNT_W-1:0] CNT_ONE   = ERR_CNT_W'(1);

   state_t               state_q;
   logic [3:0]           sync_cnt_q;
   logic [WIDTH-1:0]     prev1_q, prev2_q, prev3_q;
   logic                 prev_div_q, prev_sel_q;
   logic                 busy_q, locked_q, err_q;
   logic [3:0]           err_mask_q;
   logic [ERR_CNT_W-1:0] err_cnt_q;

   logic [WIDTH-1:0]     exp1_d, exp2_d, exp3_d;
   logic [3:0]           mis_d;
   logic                 any_mis_d;

   always_comb begin
      exp1_d = prev1_q + ONE;
      exp2_d = prev2_q + ONE;
      exp3_d = prev3_q + ONE;
      mis_d  = '0;
      if (state_q == CHECK) begin
         mis_d[0] = (mon.CNTR_IN1 != exp1_d);
         mis_d[1] = (mon.CNTR_IN2 != exp2_d);
         // ch3 is only meaningful once the mux has selected the counter for two cycles running
         mis_d[2] = mon.SELECT_3 && prev_sel_q && (mon.CNTR_IN3 != exp3_d);
         mis_d[3] = (mon.DIV_IN != ~prev_div_q);
      end
      any_mis_d = |mis_d;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         sync_cnt_q <= '0;
         prev1_q    <= '0;
         prev2_q    <= '0;
         prev3_q    <= '0;
         prev_div_q <= 1'b0;
         prev_sel_q <= 1'b0;
         busy_q     <= 1'b0;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
         err_mask_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         busy_q   <= (state_q != IDLE);
         locked_q <= (state_q == CHECK);

         case (state_q)
            IDLE: begin
               if (mon.START && !mon.STOP) begin
                  state_q    <= SYNC;
                  sync_cnt_q <= '0;
               end
            end
            SYNC: begin
               if (mon.STOP)
                  state_q <= IDLE;
               else if (sync_cnt_q == SYNC_LAST)
                  state_q <= CHECK;
               else
                  sync_cnt_q <= sync_cnt_q + 4'd1;
            end
            CHECK: begin
               if (mon.STOP)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase

         if (state_q != IDLE) begin
            prev1_q    <= mon.CNTR_IN1;
            prev2_q    <= mon.CNTR_IN2;
            prev3_q    <= mon.CNTR_IN3;
            prev_div_q <= mon.DIV_IN;
            prev_sel_q <= mon.SELECT_3;
         end

         // a clear coinciding with a fresh mismatch keeps only the fresh one
         if (mon.CLR_ERR) begin
            err_q      <= any_mis_d;
            err_mask_q <= mis_d;
            err_cnt_q  <= any_mis_d ? CNT_ONE : '0;
         end else begin
            err_q      <= err_q | any_mis_d;
            err_mask_q <= err_mask_q | mis_d;
            if (any_mis_d && (err_cnt_q != '1))
               err_cnt_q <= err_cnt_q + CNT_ONE;
         end
      end
   end

   assign mon.BUSY     = busy_q;
   assign mon.LOCKED   = locked_q;
   assign mon.ERR      = err_q;
   assign mon.ERR_MASK = err_mask_q;
   assign mon.ERR_CNT  = err_cnt_q;
endmodule
